// File: rtl/riscv_v_scoreboard_if.sv
// -----------------------------------------------------------------------------
// riscv_v_scoreboard_if
// Bundles the ID, EXE and long-latency completion signals seen by the vector
// hazard scoreboard, together with its stall/issue and status outputs.
//   master : decode/issue side (drives ID/EXE/completion, reads status)
//   slave  : the scoreboard itself
// -----------------------------------------------------------------------------
interface riscv_v_scoreboard_if #(
  parameter int NUM_VREGS       = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
  // ID stage
  logic                 id_valid;
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic                 id_mask_used;
  logic [4:0]           id_rd;
  logic                 id_rd_wr;
  logic                 id_long_lat;
  logic                 id_fence;
  // EXE stage
  logic                 exe_valid;
  logic                 exe_is_load;
  logic [4:0]           exe_rd;
  logic                 exe_rd_wr;
  // long-latency completion
  logic                 lld_valid;
  logic [4:0]           lld_rd;
  // scoreboard outputs
  logic                 id_stall;
  logic                 id_issue;
  logic [NUM_VREGS-1:0] busy_vec;
  logic [CNT_W-1:0]     outstanding;
  logic                 fence_draining;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_mask_used,
           id_rd, id_rd_wr, id_long_lat, id_fence,
           exe_valid, exe_is_load, exe_rd, exe_rd_wr,
           lld_valid, lld_rd,
    input  id_stall, id_issue, busy_vec, outstanding, fence_draining
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_mask_used,
           id_rd, id_rd_wr, id_long_lat, id_fence,
           exe_valid, exe_is_load, exe_rd, exe_rd_wr,
           lld_valid, lld_rd,
    output id_stall, id_issue, busy_vec, outstanding, fence_draining
  );
endinterface

// File: rtl/riscv_v_scoreboard.sv
// -----------------------------------------------------------------------------
// riscv_v_scoreboard
// Hazard scoreboard and issue controller at the vector decode/issue stage.
// Stalls an ID instruction when an operand/mask cannot come from the MEM/WB
// bypass: pending long-latency results, load-use in EXE, WAW on a pending
// register, a full outstanding queue, or a fence waiting for drain.
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   sb    : slave modport of riscv_v_scoreboard_if (ID/EXE/completion inputs,
//           id_stall/id_issue/busy_vec/outstanding/fence_draining outputs)
// -----------------------------------------------------------------------------
module riscv_v_scoreboard #(
  parameter int NUM_VREGS       = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_v_scoreboard_if.slave   sb
);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_e               state_q, state_d;
  logic [NUM_VREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     outst_q, outst_d;

  logic raw_ll, waw, lduse, full, fence_hz, drain_hz;
  logic stall, issue, inc, dec;

  // Hazard detection: registered state only, so a completion clears its
  // hazard one cycle later.
  always_comb begin
    raw_ll   = (sb.id_rs1_used  & busy_q[sb.id_rs1]) |
               (sb.id_rs2_used  & busy_q[sb.id_rs2]) |
               (sb.id_mask_used & busy_q[0]);
    waw      = sb.id_rd_wr & busy_q[sb.id_rd];
    lduse    = sb.exe_valid & sb.exe_is_load & sb.exe_rd_wr &
               ((sb.id_rs1_used  & (sb.id_rs1 == sb.exe_rd)) |
                (sb.id_rs2_used  & (sb.id_rs2 == sb.exe_rd)) |
                (sb.id_mask_used & (sb.exe_rd == 5'd0)));
    full     = sb.id_long_lat & (outst_q == MAX_CNT);
    fence_hz = sb.id_fence & ((state_q == ST_DRAIN) | (outst_q != '0));
    drain_hz = (state_q == ST_DRAIN);
    stall    = sb.id_valid & (raw_ll | waw | lduse | full | fence_hz | drain_hz);
    issue    = sb.id_valid & ~stall;
  end

  assign sb.id_stall       = stall;
  assign sb.id_issue       = issue;
  assign sb.busy_vec       = busy_q;
  assign sb.outstanding    = outst_q;
  assign sb.fence_draining = (state_q == ST_DRAIN);

  // Fence FSM: leaves DRAIN once the registered count is zero, so the fence
  // issues in the first RUN cycle that sees an empty long-latency pipe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (sb.id_valid & sb.id_fence & (outst_q != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (outst_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Busy/outstanding update. Completions of ops without rd carry a non-busy
  // lld_rd, so the decrement ignores busy and is only gated by a zero count.
  // The waw stall keeps set and clear on different registers.
  always_comb begin
    inc    = issue & sb.id_long_lat;
    dec    = sb.lld_valid & (outst_q != '0);
    busy_d = busy_q;
    if (sb.lld_valid) busy_d[sb.lld_rd] = 1'b0;
    if (inc & sb.id_rd_wr) busy_d[sb.id_rd] = 1'b1;
    outst_d = outst_q;
    if (inc & ~dec)      outst_d = outst_q + 1'b1;
    else if (dec & ~inc) outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      outst_q <= outst_d;
    end
  end

endmodule
